// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the CPU data-memory port: CPU has default priority, external master gets
// bounded bursts. Define DMEM_ARB_STARVE_EN to compile in the starvation counter / forced grant.
module dmem_arbiter #(
  parameter int unsigned StarveLimit = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_mem_req_i,
  input  logic        cpu_mem_write_i,
  input  logic [31:0] cpu_data_adr_i,
  input  logic [31:0] cpu_write_data_i,
  output logic        cpu_stall_o,
  input  logic        ext_req_i,
  input  logic [4:0]  ext_len_i,
  input  logic        ext_mem_write_i,
  input  logic [31:0] ext_data_adr_i,
  input  logic [31:0] ext_write_data_i,
  output logic        ext_gnt_o,
  output logic        ext_done_o,
  output logic [31:0] ext_read_data_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_read_data_i
);

  if (StarveLimit < 1 || StarveLimit > 255) begin : gen_bad_limit
    $error("StarveLimit must be in 1..255");
  end

  typedef enum logic [0:0] {StCpu, StExt} state_e;

  state_e     state_q, state_d;
  logic [4:0] beat_cnt_q, beat_cnt_d;
  logic       done_q, done_d;
  logic       starved;
  logic       go_ext;
  logic       gnt;
  logic       we_raw;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [7:0] Limit = 8'(StarveLimit);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign starved = (wait_cnt_q == Limit);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!ext_req_i) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == StCpu) begin
      if (go_ext) begin
        wait_cnt_d = 8'd0;
      end else if (cpu_mem_req_i && (wait_cnt_q != Limit)) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign starved = 1'b0;
`endif

  assign go_ext = ext_req_i && (!cpu_mem_req_i || starved);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    gnt        = 1'b0;
    unique case (state_q)
      StCpu: begin
        if (go_ext) begin
          state_d    = StExt;
          beat_cnt_d = ext_len_i;
        end
      end
      StExt: begin
        gnt = ext_req_i;
        // Dropping ext_req mid-burst abandons the remaining beats without a done pulse.
        if (!ext_req_i) begin
          state_d = StCpu;
        end else if (beat_cnt_q == 5'd0) begin
          state_d = StCpu;
          done_d  = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q - 5'd1;
        end
      end
      default: state_d = StCpu;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StCpu;
      beat_cnt_q <= 5'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    if (state_q == StExt) begin
      we_raw      = ext_mem_write_i && gnt;
      mem_addr_o  = ext_data_adr_i;
      mem_wdata_o = ext_write_data_i;
    end else begin
      we_raw      = cpu_mem_write_i && cpu_mem_req_i;
      mem_addr_o  = cpu_data_adr_i;
      mem_wdata_o = cpu_write_data_i;
    end
  end

  assign mem_we_o        = we_raw && !rst_i;
  assign cpu_stall_o     = (state_q == StExt) && cpu_mem_req_i;
  assign ext_gnt_o       = gnt;
  assign ext_done_o      = done_q;
  assign ext_read_data_o = mem_read_data_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a beat-counting reference model and a word RAM.
module tb_dmem_arbiter;

  localparam int unsigned Limit = 4;
  localparam int unsigned NoLat = 999;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_adr, cpu_wd, ext_adr, ext_wd;
  logic [4:0]  ext_len;
  logic        cpu_stall_o, ext_gnt_o, ext_done_o, mem_we_o;
  logic [31:0] ext_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata;

  logic [31:0] ram  [2048];
  logic [31:0] mram [2048];

  int checks   = 0;
  int failures = 0;

  // Reference model: burst active flag, beats remaining (including current), starvation wait.
  bit m_active, m_done;
  int m_rem, m_wait;

  logic        obs_gnt, obs_done, obs_stall;
  logic [31:0] obs_rdata;

  assign mem_rdata = ram[mem_addr_o[12:2]];

  always #5 clk = ~clk;

  dmem_arbiter #(.StarveLimit(Limit)) u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cpu_mem_req_i    (cpu_req),
    .cpu_mem_write_i  (cpu_we),
    .cpu_data_adr_i   (cpu_adr),
    .cpu_write_data_i (cpu_wd),
    .cpu_stall_o      (cpu_stall_o),
    .ext_req_i        (ext_req),
    .ext_len_i        (ext_len),
    .ext_mem_write_i  (ext_we),
    .ext_data_adr_i   (ext_adr),
    .ext_write_data_i (ext_wd),
    .ext_gnt_o        (ext_gnt_o),
    .ext_done_o       (ext_done_o),
    .ext_read_data_o  (ext_rdata_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_read_data_i  (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_rem    = 0;
    m_wait   = 0;
  endtask

  // One clock: check outputs at negedge, then advance RAMs and model at posedge.
  task automatic step();
    logic        e_gnt, e_we, d_we;
    logic [31:0] e_addr, e_wd, d_addr, d_wd;
    bit          starve;
    @(negedge clk);
    e_gnt  = m_active && ext_req;
    e_we   = m_active ? (ext_we && e_gnt) : (cpu_we && cpu_req);
    e_addr = m_active ? ext_adr : cpu_adr;
    e_wd   = m_active ? ext_wd : cpu_wd;
    check_eq("ext_gnt", ext_gnt_o, e_gnt);
    check_eq("cpu_stall", cpu_stall_o, m_active && cpu_req);
    check_eq("ext_done", ext_done_o, m_done);
    check_eq("mem_we", mem_we_o, e_we);
    check_eq("mem_addr", mem_addr_o, e_addr);
    check_eq("mem_wdata", mem_wdata_o, e_wd);
    check_eq("ext_rdata", ext_rdata_o, mram[e_addr[12:2]]);
    obs_gnt   = ext_gnt_o;
    obs_done  = ext_done_o;
    obs_stall = cpu_stall_o;
    obs_rdata = ext_rdata_o;
    d_we      = mem_we_o;
    d_addr    = mem_addr_o;
    d_wd      = mem_wdata_o;
    @(posedge clk);
    if (d_we) ram[d_addr[12:2]] = d_wd;
    if (e_we) mram[e_addr[12:2]] = e_wd;
`ifdef DMEM_ARB_STARVE_EN
    starve = (m_wait >= int'(Limit));
`else
    starve = 1'b0;
`endif
    if (m_active) begin
      m_done = 1'b0;
      if (!ext_req) begin
        m_active = 1'b0;
      end else if (m_rem == 1) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_rem--;
      end
      if (!ext_req) m_wait = 0;
    end else begin
      m_done = 1'b0;
      if (ext_req && (!cpu_req || starve)) begin
        m_active = 1'b1;
        m_rem    = int'(ext_len) + 1;
        m_wait   = 0;
      end else if (!ext_req) begin
        m_wait = 0;
      end else if (cpu_req && m_wait < int'(Limit)) begin
        m_wait++;
      end
    end
    #1;
  endtask

  initial begin
    int lat;
    int prev_req;
    for (int i = 0; i < 2048; i++) begin
      ram[i]  = 32'd0;
      mram[i] = 32'd0;
    end
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h40; cpu_wd = 32'h5;
    ext_req = 1'b0; ext_we = 1'b0; ext_adr = 32'd0; ext_wd = 32'd0; ext_len = 5'd0;
    model_reset();

    @(negedge clk);
    check_eq("rst_we", mem_we_o, 1'b0);
    check_eq("rst_stall", cpu_stall_o, 1'b0);
    check_eq("rst_gnt", ext_gnt_o, 1'b0);
    check_eq("rst_done", ext_done_o, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;

    // CPU only: store 100 to 4096, load it back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'd4096; cpu_wd = 32'd100;
    step();
    cpu_we = 1'b0;
    step();
    check_eq("cpu_load", obs_rdata, 32'd100);
    check_eq("cpu_only_stall", obs_stall, 1'b0);
    cpu_req = 1'b0;
    step();

    // Ext burst of 4 with CPU idle.
    ext_req = 1'b1; ext_len = 5'd3; ext_we = 1'b1; ext_adr = 32'h100; ext_wd = 32'h11;
    step();
    check_eq("burst_lat", obs_gnt, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ext_adr = 32'h100 + 32'(4 * i);
      ext_wd  = 32'h11 + 32'(i);
      step();
      check_eq("burst_gnt", obs_gnt, 1'b1);
    end
    ext_req = 1'b0;
    step();
    check_eq("burst_done", obs_done, 1'b1);
    for (int i = 0; i < 4; i++) check_eq("burst_ram", ram[64 + i], 32'h11 + 32'(i));

    // Contention: CPU load of 0x100 during a burst that rewrites it.
    ext_req = 1'b1; ext_len = 5'd3; ext_adr = 32'h100; ext_wd = 32'h21;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      ext_adr = 32'h100 + 32'(4 * i);
      ext_wd  = 32'h21 + 32'(i);
      step();
      check_eq("cont_stall", obs_stall, 1'b1);
    end
    ext_req = 1'b0;
    step();
    check_eq("cont_stall_end", obs_stall, 1'b0);
    check_eq("cont_load", obs_rdata, 32'h21);

    // Starvation: CPU requests continuously while ext waits.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0;
    step();
    ext_req = 1'b1; ext_len = 5'd0; ext_we = 1'b0;
    lat = NoLat;
    for (int k = 0; k < 40; k++) begin
      step();
      if (obs_gnt && lat == NoLat) lat = k;
    end
`ifdef DMEM_ARB_STARVE_EN
    check_eq("starve_lat", lat, Limit + 1);
`else
    check_eq("starve_lat", lat, NoLat);
`endif
    ext_req = 1'b0; cpu_req = 1'b0;
    step();
    step();

    // Reset during beat 3 of 8.
    ext_req = 1'b1; ext_len = 5'd7; ext_we = 1'b1; ext_adr = 32'h200; ext_wd = 32'h31;
    step();
    for (int i = 0; i < 2; i++) begin
      ext_adr = 32'h200 + 32'(4 * i);
      ext_wd  = 32'h31 + 32'(i);
      step();
    end
    ext_adr = 32'h208; ext_wd = 32'h33; cpu_req = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_gnt", ext_gnt_o, 1'b0);
    check_eq("rst_mid_we", mem_we_o, 1'b0);
    check_eq("rst_mid_stall", cpu_stall_o, 1'b0);
    check_eq("rst_mid_done", ext_done_o, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    ext_req = 1'b0; cpu_req = 1'b0;
    check_eq("rst_mid_ram1", ram[129], 32'h32);
    check_eq("rst_mid_ram2", ram[130], 32'h0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h20; cpu_wd = 32'd100;
    step();
    cpu_we = 1'b0;
    step();
    check_eq("rst_cpu_load", obs_rdata, 32'd100);
    cpu_req = 1'b0;

    // Abort after 2 beats of an 8-beat burst.
    ext_req = 1'b1; ext_len = 5'd7; ext_we = 1'b1; ext_adr = 32'h300; ext_wd = 32'h41;
    step();
    for (int i = 0; i < 2; i++) begin
      ext_adr = 32'h300 + 32'(4 * i);
      ext_wd  = 32'h41 + 32'(i);
      step();
    end
    ext_req = 1'b0;
    step();
    check_eq("abort_gnt", obs_gnt, 1'b0);
    step();
    check_eq("abort_done", obs_done, 1'b0);
    check_eq("abort_ram1", ram[193], 32'h42);
    check_eq("abort_ram2", ram[194], 32'h0);

    // Random traffic.
    prev_req = 0;
    for (int n = 0; n < 3000; n++) begin
      cpu_req = 1'($urandom_range(0, 1));
      cpu_we  = 1'($urandom_range(0, 1));
      cpu_adr = {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
      cpu_wd  = $urandom;
      if (prev_req != 0) ext_req = ($urandom_range(0, 99) < 85);
      else ext_req = ($urandom_range(0, 99) < 30);
      prev_req = int'(ext_req);
      ext_len = 5'($urandom_range(0, 5));
      ext_we  = 1'($urandom_range(0, 1));
      ext_adr = {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
      ext_wd  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
